// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: deserialises set-2 scan codes and presents the Hack code of the held key.
// Latency: out/strobe update one cycle after the stop bit is sampled (about 5 clocks after the raw edge).
// Backpressure: none; the keyboard register downstream must accept every strobe.
//
// Ports:
//   clock      system clock, all state on the rising edge
//   reset      synchronous, active-high
//   ps2_clk    raw PS/2 clock, asynchronous to clock
//   ps2_data   raw PS/2 data, asynchronous to clock
//   out        Hack key code of the held key, 0 when none (bits 15:8 always 0)
//   strobe     one-cycle pulse whenever out changes value
//   frame_err  one-cycle pulse on a parity, stop or timeout error
//
// Build option: define SHIFT_TRACK_EN to track the shift keys.
// With it, letters map to lower/upper case and digits map to US symbols.
module ps2_keyboard #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] out,
    output logic        strobe,
    output logic        frame_err
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and glitch filter
    // ------------------------------------------------------------------
    logic           clk_s1_q, clk_s2_q;
    logic           dat_s1_q, dat_s2_q;
    logic           filt_q;
    logic [FCW-1:0] filt_cnt_q;
    logic           fall_q;     // one-cycle pulse on a filtered falling edge
    logic           bit_q;      // data bit captured at that edge

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            fall_q   <= 1'b0;
            if (clk_s2_q == filt_q) begin
                filt_cnt_q <= '0;
            end else if (int'(filt_cnt_q) >= FILTER_LEN - 1) begin
                // FILTER_LEN consecutive samples disagreed with the filtered level
                filt_q     <= clk_s2_q;
                filt_cnt_q <= '0;
                if (!clk_s2_q) begin
                    fall_q <= 1'b1;
                    bit_q  <= dat_s2_q;
                end
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: start, 8 data bits LSB first, odd parity, stop
    // ------------------------------------------------------------------
    state_t         state_q;
    logic [7:0]     data_sr_q;
    logic [2:0]     bit_cnt_q;
    logic [TCW-1:0] timer_q;
    logic           frame_err_q;
    logic           byte_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            data_sr_q   <= '0;
            bit_cnt_q   <= '0;
            timer_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (fall_q) begin
                // Timer counts cycles since the edge, the edge cycle included
                timer_q <= TCW'(1);
                case (state_q)
                    S_IDLE: begin
                        // A high "start bit" while idle is treated as line noise
                        if (!bit_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        data_sr_q <= {bit_q, data_sr_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        if (^{data_sr_q, bit_q}) begin
                            state_q <= S_STOP;
                        end else begin
                            state_q     <= S_IDLE;
                            frame_err_q <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (!bit_q) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE) begin
                if (int'(timer_q) >= TIMEOUT_CYCLES - 1) begin
                    state_q     <= S_IDLE;
                    frame_err_q <= 1'b1;
                    timer_q     <= '0;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end else begin
                timer_q <= '0;
            end
        end
    end

    // A good byte completes in the cycle its stop bit is sampled
    assign byte_done = fall_q && (state_q == S_STOP) && bit_q;

    // ------------------------------------------------------------------
    // Scan code set 2 -> Hack code
    // ------------------------------------------------------------------
    function automatic logic [7:0] base_code(input logic ext, input logic [7:0] code);
        logic [7:0] k;
        k = 8'h00;
        if (ext) begin
            case (code)
                8'h6B:   k = 8'd130;
                8'h75:   k = 8'd131;
                8'h74:   k = 8'd132;
                8'h72:   k = 8'd133;
                8'h6C:   k = 8'd134;
                8'h69:   k = 8'd135;
                8'h7D:   k = 8'd136;
                8'h7A:   k = 8'd137;
                8'h70:   k = 8'd138;
                8'h71:   k = 8'd139;
                default: k = 8'h00;
            endcase
        end else begin
            case (code)
                8'h1C: k = 8'h41; 8'h32: k = 8'h42; 8'h21: k = 8'h43; 8'h23: k = 8'h44;
                8'h24: k = 8'h45; 8'h2B: k = 8'h46; 8'h34: k = 8'h47; 8'h33: k = 8'h48;
                8'h43: k = 8'h49; 8'h3B: k = 8'h4A; 8'h42: k = 8'h4B; 8'h4B: k = 8'h4C;
                8'h3A: k = 8'h4D; 8'h31: k = 8'h4E; 8'h44: k = 8'h4F; 8'h4D: k = 8'h50;
                8'h15: k = 8'h51; 8'h2D: k = 8'h52; 8'h1B: k = 8'h53; 8'h2C: k = 8'h54;
                8'h3C: k = 8'h55; 8'h2A: k = 8'h56; 8'h1D: k = 8'h57; 8'h22: k = 8'h58;
                8'h35: k = 8'h59; 8'h1A: k = 8'h5A;
                8'h45: k = 8'h30; 8'h16: k = 8'h31; 8'h1E: k = 8'h32; 8'h26: k = 8'h33;
                8'h25: k = 8'h34; 8'h2E: k = 8'h35; 8'h36: k = 8'h36; 8'h3D: k = 8'h37;
                8'h3E: k = 8'h38; 8'h46: k = 8'h39;
                8'h29: k = 8'd32;
                8'h5A: k = 8'd128;
                8'h66: k = 8'd129;
                8'h76: k = 8'd140;
                8'h05: k = 8'd141; 8'h06: k = 8'd142; 8'h04: k = 8'd143; 8'h0C: k = 8'd144;
                8'h03: k = 8'd145; 8'h0B: k = 8'd146; 8'h83: k = 8'd147; 8'h0A: k = 8'd148;
                8'h01: k = 8'd149; 8'h09: k = 8'd150; 8'h78: k = 8'd151; 8'h07: k = 8'd152;
                default: k = 8'h00;
            endcase
        end
        return k;
    endfunction

`ifdef SHIFT_TRACK_EN
    // Letters drop to lower case without shift; digits become US symbols with it
    function automatic logic [7:0] apply_shift(input logic [7:0] k, input logic shifted);
        logic [7:0] r;
        r = k;
        if (k >= 8'h41 && k <= 8'h5A && !shifted) begin
            r = k + 8'h20;
        end else if (k >= 8'h30 && k <= 8'h39 && shifted) begin
            case (k)
                8'h30:   r = 8'h29;  // )
                8'h31:   r = 8'h21;  // !
                8'h32:   r = 8'h40;  // @
                8'h33:   r = 8'h23;  // #
                8'h34:   r = 8'h24;  // $
                8'h35:   r = 8'h25;  // %
                8'h36:   r = 8'h5E;  // ^
                8'h37:   r = 8'h26;  // &
                8'h38:   r = 8'h2A;  // *
                8'h39:   r = 8'h28;  // (
                default: r = k;
            endcase
        end
        return r;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Make/break decoder
    // ------------------------------------------------------------------
    logic [7:0] out_q, out_d;
    logic       strobe_q, strobe_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] key;
`ifdef SHIFT_TRACK_EN
    logic       shift_q, shift_d;
    logic [8:0] held_q, held_d;     // {extended, scan code} of the key behind out
    logic       is_shift;
`endif

    always_comb begin
        key      = base_code(ext_q, data_sr_q);
        out_d    = out_q;
        strobe_d = 1'b0;
        ext_d    = ext_q;
        brk_d    = brk_q;
`ifdef SHIFT_TRACK_EN
        shift_d  = shift_q;
        held_d   = held_q;
        is_shift = !ext_q && (data_sr_q == 8'h12 || data_sr_q == 8'h59);
        if (!ext_q) begin
            key = apply_shift(key, shift_q);
        end
`endif
        if (byte_done) begin
            if (data_sr_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (data_sr_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
`ifdef SHIFT_TRACK_EN
                if (is_shift) begin
                    shift_d = !brk_q;
                end else if (brk_q) begin
                    // Match on the physical key so a shift change between make
                    // and break still releases it
                    if (out_q != 8'h00 && held_q == {ext_q, data_sr_q}) begin
                        out_d    = 8'h00;
                        strobe_d = 1'b1;
                    end
                end else if (key != 8'h00) begin
                    held_d   = {ext_q, data_sr_q};
                    out_d    = key;
                    strobe_d = (key != out_q);
                end
`else
                if (brk_q) begin
                    if (key != 8'h00 && key == out_q) begin
                        out_d    = 8'h00;
                        strobe_d = 1'b1;
                    end
                end else if (key != 8'h00) begin
                    out_d    = key;
                    strobe_d = (key != out_q);
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q    <= 8'h00;
            strobe_q <= 1'b0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
`ifdef SHIFT_TRACK_EN
            shift_q  <= 1'b0;
            held_q   <= '0;
`endif
        end else begin
            out_q    <= out_d;
            strobe_q <= strobe_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
`ifdef SHIFT_TRACK_EN
            shift_q  <= shift_d;
            held_q   <= held_d;
`endif
        end
    end

    assign out       = {8'h00, out_q};
    assign strobe    = strobe_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
module tb_ps2_keyboard;

    localparam int FL   = 2;
    localparam int TO   = 400;
    localparam int HALF = 20;   // half of the 40-cycle PS/2 bit period

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] out;
    logic        strobe;
    logic        frame_err;

    int total         = 0;
    int bad           = 0;
    int cyc           = 0;
    int fe_count      = 0;
    int fe_cyc        = 0;
    int strobe_cyc    = 0;
    int last_fall_cyc = 0;

    logic [15:0] exp_q[$];

    ps2_keyboard #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .out      (out),
        .strobe   (strobe),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        total++;
        if (val < lo || val > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    // Scoreboard monitor: every strobe pops the next expected out value
    always @(negedge clock) begin
        if (strobe) begin
            strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL strobe_unexpected: got out=%h expected no strobe", out);
            end else begin
                chk("strobe_out", out, exp_q.pop_front());
            end
        end
        if (frame_err) begin
            fe_count++;
            fe_cyc = cyc;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Sends the first nfall bits of a frame; a full frame has 11
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nfall);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nfall; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
        wait_cyc(2 * HALF);
    endtask

    initial begin
        int fe_before;
        bit seen;

        reset = 1'b1;
        wait_cyc(5);
        chk("reset_out", out, 16'h0000);
        chk("reset_strobe", {15'b0, strobe}, 16'h0000);
        chk("reset_frame_err", {15'b0, frame_err}, 16'h0000);
        reset = 1'b0;
        wait_cyc(10);

        // 1: 'A' make
        exp_q.push_back(16'h0041);
        send_byte(8'h1C);
        chk("t1_out", out, 16'h0041);
        chk_range("t1_strobe_latency", strobe_cyc - last_fall_cyc, 4, 6);
        chk("t1_no_frame_err", 16'(fe_count), 16'd0);

        // 2: break of 'A', then break of a key that is not held
        exp_q.push_back(16'h0000);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("t2_release", out, 16'h0000);
        exp_q.push_back(16'h0041);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h32);
        chk("t2_other_break", out, 16'h0041);
        exp_q.push_back(16'h0000);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("t2_queue", 16'(exp_q.size()), 16'd0);

        // 3: extended up arrow make/break, then keypad 8 (unmapped)
        exp_q.push_back(16'd131);
        send_byte(8'hE0);
        send_byte(8'h75);
        chk("t3_up_make", out, 16'd131);
        exp_q.push_back(16'h0000);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("t3_up_break", out, 16'h0000);
        send_byte(8'h75);
        chk("t3_kp8", out, 16'h0000);
        chk("t3_queue", 16'(exp_q.size()), 16'd0);

        // 4: bad parity, then a frame cut off after 5 data bits
        exp_q.push_back(16'h0041);
        send_byte(8'h1C);
        fe_before = fe_count;
        send_frame(8'h1C, 1'b1, 11);
        wait_cyc(2 * HALF);
        chk("t4_parity_err", 16'(fe_count - fe_before), 16'd1);
        chk("t4_out_kept", out, 16'h0041);
        fe_before = fe_count;
        send_frame(8'h1C, 1'b0, 6);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            wait_cyc(1);
            if (fe_count != fe_before) seen = 1'b1;
        end
        chk("t4_timeout_seen", {15'b0, seen}, 16'h0001);
        chk_range("t4_timeout_delay", fe_cyc - last_fall_cyc, 402, 406);
        wait_cyc(10);
        // A clean frame straight after shows the FSM is back in idle
        exp_q.push_back(16'h0000);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("t4_idle_after_timeout", out, 16'h0000);
        chk("t4_frame_errs", 16'(fe_count), 16'd2);

        // 5: shift then 'A', release shift, 'A' again
        exp_q.push_back(16'h0041);
        send_byte(8'h12);
        send_byte(8'h1C);
        chk("t5_shift_a", out, 16'h0041);
`ifdef SHIFT_TRACK_EN
        exp_q.push_back(16'h0061);
`endif
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'h1C);
`ifdef SHIFT_TRACK_EN
        chk("t5_unshift_a", out, 16'h0061);
`else
        chk("t5_repeat_a", out, 16'h0041);
`endif
        exp_q.push_back(16'h0000);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("t5_release", out, 16'h0000);
        chk("t5_queue", 16'(exp_q.size()), 16'd0);

        // 6: reset during data bit 3, then a clean space
        send_frame(8'h29, 1'b0, 4);
        wait_cyc(HALF / 2);
        reset = 1'b1;
        wait_cyc(3);
        chk("t6_reset_out", out, 16'h0000);
        reset = 1'b0;
        wait_cyc(10);
        exp_q.push_back(16'h0020);
        send_byte(8'h29);
        chk("t6_space", out, 16'h0020);
        chk("t6_no_new_frame_err", 16'(fe_count), 16'd2);
        chk("final_queue", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test expected finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
